// File: rtl/io_slave_pkg.sv
// Shared constants for the CPU-bus I/O responder: register offsets,
// TSTAT bit positions and the bus data width.
package io_pkg;

    localparam int DW = 8;

    localparam logic [2:0] OFF_LEDR  = 3'd0;
    localparam logic [2:0] OFF_LEDG  = 3'd1;
    localparam logic [2:0] OFF_SW    = 3'd2;
    localparam logic [2:0] OFF_KEY   = 3'd3;
    localparam logic [2:0] OFF_TCNT  = 3'd4;
    localparam logic [2:0] OFF_TPRE  = 3'd5;
    localparam logic [2:0] OFF_TCMP  = 3'd6;
    localparam logic [2:0] OFF_TSTAT = 3'd7;

    localparam int TSTAT_FLAG = 0;
    localparam int TSTAT_EN   = 1;

    typedef logic [DW-1:0] io_byte_t;

endpackage

// File: rtl/io_slave_if.sv
// CPU byte-bus connection between the bus initiator (master) and the
// I/O responder (slave): address, write data/strobe, registered read data and hit.
interface io_slave_if;
    import io_pkg::*;

    logic [15:0]   addr;
    logic [DW-1:0] wdata;
    logic          we;
    logic [DW-1:0] rdata;
    logic          hit;

    modport master (
        output addr,
        output wdata,
        output we,
        input  rdata,
        input  hit
    );

    modport slave (
        input  addr,
        input  wdata,
        input  we,
        output rdata,
        output hit
    );

endinterface

// File: rtl/io_slave_timer.sv
// Prescaled 8-bit timer: TCNT/TPRE/TCMP/TSTAT, compare match that reloads
// TCNT with 0 on the same tick, and a sticky match flag driving irq_o.
module io_timer
    import io_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_tcnt_i,
    input  logic          wr_tpre_i,
    input  logic          wr_tcmp_i,
    input  logic          wr_tstat_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] tcnt_o,
    output logic [DW-1:0] tpre_o,
    output logic [DW-1:0] tcmp_o,
    output logic [DW-1:0] tstat_o,
    output logic          irq_o
);

    logic [DW-1:0] tcnt_q, tcnt_d;
    logic [DW-1:0] pcnt_q, pcnt_d;
    logic [DW-1:0] tpre_q, tpre_d;
    logic [DW-1:0] tcmp_q, tcmp_d;
    logic          flag_q, flag_d;
    logic          en_q,   en_d;
    logic          tick;
    logic          match;

    always_comb begin
        tick   = en_q && (pcnt_q == tpre_q);
        match  = tick && (tcnt_q == tcmp_q);
        tcnt_d = tcnt_q;
        pcnt_d = pcnt_q;
        tpre_d = tpre_q;
        tcmp_d = tcmp_q;
        en_d   = en_q;

        if (en_q) begin
            if (tick) begin
                pcnt_d = '0;
                tcnt_d = match ? '0 : tcnt_q + 8'd1;
            end else begin
                pcnt_d = pcnt_q + 8'd1;
            end
        end

        // Software writes override the count advance on the same edge.
        if (wr_tcnt_i) begin
            tcnt_d = '0;
            pcnt_d = '0;
        end
        if (wr_tpre_i) begin
            tpre_d = wdata_i;
            pcnt_d = '0;
        end
        if (wr_tcmp_i) begin
            tcmp_d = wdata_i;
        end
        if (wr_tstat_i) begin
            en_d = wdata_i[TSTAT_EN];
        end

        // A match on the clearing edge keeps the flag set.
        flag_d = (flag_q & ~(wr_tstat_i & wdata_i[TSTAT_FLAG])) | match;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt_q <= '0;
            pcnt_q <= '0;
            tpre_q <= '0;
            tcmp_q <= '0;
            flag_q <= 1'b0;
            en_q   <= 1'b0;
        end else begin
            tcnt_q <= tcnt_d;
            pcnt_q <= pcnt_d;
            tpre_q <= tpre_d;
            tcmp_q <= tcmp_d;
            flag_q <= flag_d;
            en_q   <= en_d;
        end
    end

    always_comb begin
        tstat_o             = '0;
        tstat_o[TSTAT_FLAG] = flag_q;
        tstat_o[TSTAT_EN]   = en_q;
    end

    assign tcnt_o = tcnt_q;
    assign tpre_o = tpre_q;
    assign tcmp_o = tcmp_q;
    assign irq_o  = flag_q;

endmodule

// File: rtl/io_slave.sv
// Memory-mapped I/O responder on an 8-byte window of the CPU byte bus: LEDs,
// synchronized switches/keys with sticky press flags, and the timer when IO_TIMER_EN is defined.
module io_slave
    import io_pkg::*;
#(
    parameter logic [15:0] BASE        = 16'h2000,
    parameter int          SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    io_slave_if.slave     bus,
    output logic [DW-1:0] ledr_o,
    output logic [DW-1:0] ledg_o,
    input  logic [DW-1:0] sw_i,
    input  logic [3:0]    key_i,
    output logic          tmr_irq_o
);

    logic          sel;
    logic [2:0]    off;
    logic          wr_ledr, wr_ledg, wr_key;

    logic [DW-1:0] ledr_q, ledr_d;
    logic [DW-1:0] ledg_q, ledg_d;
    logic [3:0]    kflag_q, kflag_d;
    logic [3:0]    key_prev_q;
    logic [3:0]    key_s;
    logic [3:0]    key_rise;
    logic [DW-1:0] sw_s;
    logic [DW-1:0] rd_mux;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          hit_q;

    logic [SYNC_STAGES-1:0][DW-1:0] sw_sync_q;
    logic [SYNC_STAGES-1:0][3:0]    key_sync_q;

    assign sel     = (bus.addr[15:3] == BASE[15:3]);
    assign off     = bus.addr[2:0];
    assign wr_ledr = bus.we & sel & (off == OFF_LEDR);
    assign wr_ledg = bus.we & sel & (off == OFF_LEDG);
    assign wr_key  = bus.we & sel & (off == OFF_KEY);

    // Keys are active-low on the pins; invert before synchronizing so 1 = pressed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_sync_q  <= '0;
            key_sync_q <= '0;
            key_prev_q <= '0;
        end else begin
            sw_sync_q  <= {sw_sync_q[SYNC_STAGES-2:0], sw_i};
            key_sync_q <= {key_sync_q[SYNC_STAGES-2:0], ~key_i};
            key_prev_q <= key_s;
        end
    end

    assign sw_s     = sw_sync_q[SYNC_STAGES-1];
    assign key_s    = key_sync_q[SYNC_STAGES-1];
    assign key_rise = key_s & ~key_prev_q;

    always_comb begin
        ledr_d  = wr_ledr ? bus.wdata : ledr_q;
        ledg_d  = wr_ledg ? bus.wdata : ledg_q;
        kflag_d = (kflag_q & ~(wr_key ? bus.wdata[7:4] : 4'h0)) | key_rise;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ledr_q  <= '0;
            ledg_q  <= '0;
            kflag_q <= '0;
        end else begin
            ledr_q  <= ledr_d;
            ledg_q  <= ledg_d;
            kflag_q <= kflag_d;
        end
    end

`ifdef IO_TIMER_EN
    logic          wr_tcnt, wr_tpre, wr_tcmp, wr_tstat;
    logic [DW-1:0] tcnt, tpre, tcmp, tstat;
    logic          timer_irq;

    assign wr_tcnt  = bus.we & sel & (off == OFF_TCNT);
    assign wr_tpre  = bus.we & sel & (off == OFF_TPRE);
    assign wr_tcmp  = bus.we & sel & (off == OFF_TCMP);
    assign wr_tstat = bus.we & sel & (off == OFF_TSTAT);

    io_timer u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_tcnt_i  (wr_tcnt),
        .wr_tpre_i  (wr_tpre),
        .wr_tcmp_i  (wr_tcmp),
        .wr_tstat_i (wr_tstat),
        .wdata_i    (bus.wdata),
        .tcnt_o     (tcnt),
        .tpre_o     (tpre),
        .tcmp_o     (tcmp),
        .tstat_o    (tstat),
        .irq_o      (timer_irq)
    );

    assign tmr_irq_o = timer_irq;
`else
    assign tmr_irq_o = 1'b0;
`endif

    // Read mux sees pre-edge register values, so a read during a write returns old data.
    always_comb begin
        rd_mux = '0;
        case (off)
            OFF_LEDR:  rd_mux = ledr_q;
            OFF_LEDG:  rd_mux = ledg_q;
            OFF_SW:    rd_mux = sw_s;
            OFF_KEY:   rd_mux = {kflag_q, key_s};
`ifdef IO_TIMER_EN
            OFF_TCNT:  rd_mux = tcnt;
            OFF_TPRE:  rd_mux = tpre;
            OFF_TCMP:  rd_mux = tcmp;
            OFF_TSTAT: rd_mux = tstat;
`endif
            default:   rd_mux = '0;
        endcase
        rdata_d = sel ? rd_mux : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
            hit_q   <= 1'b0;
        end else begin
            rdata_q <= rdata_d;
            hit_q   <= sel;
        end
    end

    assign bus.rdata = rdata_q;
    assign bus.hit   = hit_q;
    assign ledr_o    = ledr_q;
    assign ledg_o    = ledg_q;

endmodule

// File: doc/io_slave.md
# io_slave

Memory-mapped I/O responder on the CPU byte bus (addr/di/do/we), the peripheral-side counterpart of the CPU's bus initiator. It occupies an 8-byte window and provides:
- LED output registers
- synchronized switch/key inputs with sticky key-press flags
- a prescaled 8-bit timer with compare match and interrupt level

Top level routes `cpu_di` from this block when `hit` is high and from RAM otherwise.

## Interface
- `BASE`, 16'h2000: byte address of offset 0; window is `BASE`..`BASE+7`, must be 8-aligned.
- `SYNC_STAGES`, 2: flop stages on `sw`/`key` inputs (≥2).

- `clk`  in  1: clock; top level drives it with `~cpu_clk`, the same as RAM.
- `rst`  in  1: asynchronous, active-low reset.
- `addr`  in  16: CPU byte address.
- `di`  in  8: write data from the CPU (`cpu_do`).
- `we`  in  1: write strobe from the CPU.
- `do`  out  8: registered read data.
- `hit`  out  1: registered; high when the previous-edge address was in the window.
- `ledr`  out  8: red LED register.
- `ledg`  out  8: green LED register.
- `sw`  in  8: asynchronous switches.
- `key`  in  4: asynchronous push buttons, active-low.
- `tmr_irq`  out  1: level, equal to the timer match flag.

## Operation
Decode: `sel = (addr[15:3] == BASE[15:3])`; `off = addr[2:0]`. Writes with `!sel` are ignored.

Register map:
- 0 LEDR: RW.
- 1 LEDG: RW.
- 2 SW: RO, synchronized `sw`.
- 3 KEY: bits [3:0] are synchronized `~key` (1 = pressed). Bits [7:4] are sticky press flags, set on a synchronized 0→1 of the matching bit in [3:0]. Writing 1 to a bit in [7:4] clears it; writing 0 leaves it unchanged; bits [3:0] ignore writes.
- 4 TCNT: RO current count. Any write clears TCNT and the prescaler count to 0.
- 5 TPRE: RW prescaler. The count advances once every `TPRE+1` clocks while enabled. A write to TPRE also clears the prescaler count.
- 6 TCMP: RW compare value.
- 7 TSTAT: bit0 = match flag (write 1 to clear); bit1 = enable (RW); bits [7:2] read 0 and ignore writes.

Timer rules:
- On the tick where `TCNT == TCMP`: set the flag and load TCNT with 0 on that same tick, so the period is `(TCMP+1)*(TPRE+1)` clocks.
- Disabling freezes both TCNT and the prescaler count.
- Set and clear of the flag in the same cycle: set wins. The same rule applies to the key flags.

Reset values: all registers, synchronizer flops, `do`, `hit`, `ledr`, `ledg` and `tmr_irq` are 0. Reset asserted mid-count clears everything immediately, with no clock needed.

## Timing
- Read: on each `clk` rising edge, `do <= sel ? reg[off] : 8'h00` and `hit <= sel`. Data is valid after the edge and stays valid until the next edge. Latency 1 edge, matching RAM.
- Read during a write to the same offset returns the pre-write value.
- Write: the register updates at the same edge on which `we & sel` is sampled.
- Input path: a `sw`/`key` change is visible at offsets 2/3 `SYNC_STAGES` edges later.
- Key flag: set one edge after the synchronized bit rises. `tmr_irq` rises on the same edge as the TSTAT flag.
- TCNT reads return the value before that edge's increment.

## Configuration
- `IO_TIMER_EN` defined: timer present as described.
- `IO_TIMER_EN` undefined: offsets 4–7 read 8'h00, writes to them are ignored, `tmr_irq` is tied to 0, and no timer flops are instantiated.
- LED and KEY/SW behaviour is identical in both builds.

## Structure
- Package `io_pkg` holds:
  - offset constants `OFF_LEDR`…`OFF_TSTAT` (3-bit);
  - TSTAT bit indices `TSTAT_FLAG=0`, `TSTAT_EN=1`;
  - data width constant `DW=8`.
- Sub-module `io_timer` holds TCNT/TPRE/TCMP/TSTAT, the prescaler and the match logic. Its inputs are the write strobes and data for those offsets; its outputs are register read values and `irq`. It is instantiated only under `IO_TIMER_EN`.
- Synchronizers, key edge detection and the read mux stay in `io_slave`.

## Test plan
- Reset, then write 8'hA5 to `BASE+0` and 8'h3C to `BASE+1`:
  - `ledr`=A5 and `ledg`=3C on the write edge;
  - reading back gives `do`=A5 and `do`=3C one edge later, each with `hit`=1.
- Read address 16'h0002 (outside the window): `hit`=0, `do`=00; a write there leaves `ledr`/`ledg` unchanged.
- Drive `sw`=8'h5A: read of offset 2 returns 5A only from edge `SYNC_STAGES` onward.
- Pulse `key[1]` low for 5 clocks, then release:
  - KEY reads 8'h22 while held and 8'h20 after release;
  - writing 8'h20 clears the flag so KEY reads 8'h00;
  - a press arriving on the clear edge leaves the flag set.
- With TPRE=1, TCMP=3 and TSTAT=8'h02:
  - TCNT counts 0,0,1,1,2,2,3,3,0 (one value per clock);
  - the flag and `tmr_irq` rise at edge 8 and stay high until TSTAT is written with 8'h03;
  - asserting `rst` low mid-count zeroes all outputs asynchronously.
- Build without `IO_TIMER_EN`: writing 8'hFF to offsets 4–7 leaves reads at 00 and `tmr_irq`=0.
